psum_ofifo: RTL
===============

# psum_ofifo

Output collector at the south edge of the systolic MAC array. Each column of the bottom `mac_row` delivers partial sums on its own `valid` strobe, skewed by one cycle per column. This block queues each column independently and re-aligns them into full-width rows. A row is released to the downstream reader only when every column holds at least one entry.

## Interface
- `col`, 8, number of array columns (one lane per column)
- `psum_bw`, 16, partial-sum width per column
- `depth`, 64, entries per column lane; power of two, ≥ 2

- `clk`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-low reset; all state clears while low
- `in`  input  psum_bw*col  per-column psums; lane i is bits `[psum_bw*(i+1)-1 : psum_bw*i]`, driven from the array's `out_s`
- `wr`  input  col  per-column write strobes, driven from the array's `valid`
- `rd`  input  1  pop one aligned row
- `out`  output  psum_bw*col  aligned row, same lane packing as `in`
- `out_valid`  output  1  `out` holds a freshly popped row this cycle
- `o_valid`  output  1  every lane non-empty; a row is available
- `o_full`  output  1  at least one lane is full
- `o_overflow`  output  1  sticky: a write was dropped on a full lane

## Operation
- Each lane has its own circular buffer of `depth` entries.
  - Each lane has its own write pointer.
  - Pointers are `log2(depth)+1` bits wide; the extra MSB is the wrap bit.
- All lanes share one read pointer, because pops always remove one entry from every lane together.
- Lane i state is derived from its pointers:
  - empty when `wptr[i] == rptr`
  - full when the low bits are equal and the MSBs differ
- Write, lane i: when `wr[i]` is high, store lane i of `in` at `wptr[i]` and increment the pointer. Lanes are independent; any subset of `wr` may be high in a cycle.
- Accepted read: `rd && o_valid`.
  - All lanes at `rptr` are captured into `out`.
  - `out_valid` is set to 1 and `rptr` is incremented.
- `rd` while `!o_valid` is ignored:
  - pointers and `out` are unchanged
  - `out_valid` is 0 next cycle
- `out` holds its last value until the next accepted read.
- Status outputs:
  - `o_valid` is the AND over lanes of non-empty.
  - `o_full` is the OR over lanes of full.
  - Both are combinational from the pointers.
- Full lane with `wr[i]` high and no accepted read in the same cycle:
  - the write is dropped and `wptr[i]` is unchanged
  - `o_overflow` is set and stays set until reset
- Full lane with `wr[i]` high and an accepted read in the same cycle: the write is accepted, because the pop frees a slot in that edge.
- Empty lane with `wr[i]` high and `rd` high in the same cycle: the write lands, but no pop occurs (`o_valid` was 0). There is no bypass from `in` to `out`.
- Pointer wrap is natural modulo `2*depth`; there is no special-casing.
- No arithmetic is performed on data; psums pass through bit-exact.

## Timing
- Reset values:
  - `out` = 0, `out_valid` = 0, `o_overflow` = 0
  - all pointers = 0, so `o_valid` = 0 and `o_full` = 0
  - buffer contents are don't-care
- Write latency: data written at edge t is visible to the `o_valid` calculation after edge t. The earliest accepted `rd` is in cycle t+1.
- Read latency: with `rd` accepted in cycle t, `out` and `out_valid` are valid in cycle t+1.
- Throughput: one row per cycle while `o_valid` stays high.
  - `rd` may be held high continuously.
  - `out_valid` drops for any cycle after a non-accepted `rd`.
- Column skew: lane i of array row r arrives i cycles after lane 0. `o_valid` rises in the cycle after lane `col-1` is written.
- Reset asserted mid-operation: all pointers, `out`, `out_valid` and `o_overflow` clear immediately. Buffered data is discarded, with no partial-row output.
- The first edge after reset deassertion is fully functional.

## Test plan
- **Reset:** pulse `reset` low mid-stream after 3 rows are queued.
  - Required: `o_valid`=0, `out`=0, `out_valid`=0 immediately.
  - Required: the next row written reads back as the first row.
- **Skewed fill:** write lane i with value `16*r + i` at cycle `r + i`, for 4 rows. Hold `rd` high.
  - Required: `o_valid` rises the cycle after lane 7 of row 0 is written.
  - Required: `out` shows rows 0..3 in order, each with lane i = `16*r + i`, and `out_valid` high for 4 consecutive cycles.
- **Read on empty:** with lanes 0..6 holding one entry and lane 7 empty, assert `rd`.
  - Required: `out_valid`=0 and `out` unchanged.
  - Then write lane 7 = 0x00AA. Required: the next `rd` returns that row with lane 7 = 0x00AA.
- **Full and overflow:** fill lane 3 to 64 entries with no reads, other lanes holding fewer.
  - Required: `o_full`=1.
  - Write lane 3 once more. Required: `o_overflow`=1 and `wptr[3]` unchanged.
  - Fill the other lanes, then pop one row while writing lane 3. Required: the write is accepted and `o_overflow` stays 1.
- **Wrap-around:** stream 200 rows (index 0..199) through with `depth`=64, interleaving bursts of 10 writes and 10 reads.
  - Required: every popped row matches in order with no loss.
  - Required: `o_full` never asserts and `o_overflow` stays 0.
- **Simultaneous read/write steady state:** keep every lane at 1 entry, and each cycle write a new row while reading.
  - Required: `o_valid` stays 1 and the rows are returned in order.

Source files
------------

// File: rtl/psum_ofifo_if.sv
// Bus between the systolic array south edge and its psum output FIFO.
// The master side writes skewed column data and pops aligned rows.
interface psum_ofifo_if #(
  parameter int unsigned col     = 8,
  parameter int unsigned psum_bw = 16
);
  logic [psum_bw*col-1:0] in;
  logic [col-1:0]         wr;
  logic                   rd;
  logic [psum_bw*col-1:0] out;
  logic                   out_valid;
  logic                   o_valid;
  logic                   o_full;
  logic                   o_overflow;

  modport master (
    output in, wr, rd,
    input  out, out_valid, o_valid, o_full, o_overflow
  );

  modport slave (
    input  in, wr, rd,
    output out, out_valid, o_valid, o_full, o_overflow
  );
endinterface

// File: rtl/psum_ofifo.sv
// Per-column partial-sum queues that re-align skewed column outputs
// into full-width rows; one shared read pointer pops all lanes together.
module psum_ofifo #(
  parameter int unsigned col     = 8,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned depth   = 64
) (
  input logic         clk,
  input logic         reset,
  psum_ofifo_if.slave bus
);
  localparam int unsigned aw = $clog2(depth);
  typedef logic [aw:0] ptr_t;

  logic [psum_bw-1:0]     mem [col][depth];
  ptr_t                   wptr [col];
  ptr_t                   rptr;
  logic [col-1:0]         lane_empty;
  logic [col-1:0]         lane_full;
  logic [col-1:0]         wr_en;
  logic                   rd_ok;
  logic                   drop;
  logic [psum_bw*col-1:0] out_q;
  logic                   out_valid_q;
  logic                   overflow_q;

  always_comb begin
    lane_empty = '0;
    lane_full  = '0;
    wr_en      = '0;
    drop       = 1'b0;
    for (int unsigned i = 0; i < col; i++) begin
      lane_empty[i] = (wptr[i] == rptr);
      lane_full[i]  = (wptr[i][aw-1:0] == rptr[aw-1:0]) && (wptr[i][aw] != rptr[aw]);
    end
    rd_ok = bus.rd && !(|lane_empty);
    // A pop in the same edge frees the slot a full lane needs.
    for (int unsigned i = 0; i < col; i++) begin
      wr_en[i] = bus.wr[i] && (!lane_full[i] || rd_ok);
      drop     = drop || (bus.wr[i] && lane_full[i] && !rd_ok);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < col; i++) begin
      if (wr_en[i]) mem[i][wptr[i][aw-1:0]] <= bus.in[psum_bw*i +: psum_bw];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < col; i++) wptr[i] <= '0;
      rptr        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < col; i++) begin
        if (wr_en[i]) wptr[i] <= wptr[i] + ptr_t'(1);
      end
      out_valid_q <= rd_ok;
      if (rd_ok) begin
        rptr <= rptr + ptr_t'(1);
        for (int unsigned i = 0; i < col; i++) begin
          out_q[psum_bw*i +: psum_bw] <= mem[i][rptr[aw-1:0]];
        end
      end
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign bus.out        = out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.o_valid    = !(|lane_empty);
  assign bus.o_full     = |lane_full;
  assign bus.o_overflow = overflow_q;
endmodule
